// File: rtl/alu_op_issuer.sv
// alu_op_issuer: collects one-hot ALU operation requests, arbitrates them
// round-robin and issues one decoder address at a time, followed by a
// programmable idle gap so each decoder strobe clears before the next op.
//
// Handshake: address/addr_valid form a valid/ready source. Once addr_valid
// rises, address is held constant until the edge where addr_ready=1, which
// is the single accept edge; addr_ready while addr_valid=0 has no effect.
module alu_op_issuer #(
  parameter int NUM_OPS    = 8,  // request lines; index is the issued address
  parameter int ADDR_W     = 3,  // 2**ADDR_W must cover NUM_OPS
  parameter int GAP_CYCLES = 1,  // idle cycles after each accept (0 allowed)
  parameter int GAP_W      = 4   // GAP_CYCLES must fit in GAP_W bits
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_OPS-1:0] req,
  input  logic               flush,
  input  logic               addr_ready,
  output logic [ADDR_W-1:0]  address,
  output logic               addr_valid,
  output logic [NUM_OPS-1:0] grant,
  output logic [NUM_OPS-1:0] pending,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [GAP_W-1:0]   gap_cnt;
  logic [ADDR_W-1:0]  winner;
  logic               found;
  logic               accept;
  logic [NUM_OPS-1:0] addr_onehot;
  logic [NUM_OPS-1:0] clear_mask;
  logic [ADDR_W-1:0]  ptr_next;

  // Round-robin pick: first pending bit at or above ptr, else wrap to the lowest pending bit.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (!found && pending[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        winner = ADDR_W'(i);
      end
    end
    for (int i = 0; i < NUM_OPS; i++) begin
      if (!found && pending[i]) begin
        found  = 1'b1;
        winner = ADDR_W'(i);
      end
    end
  end

  // Accept decode, the bit retired by an accept, and the pointer just past it.
  always_comb begin
    accept      = (state == ISSUE) && addr_ready;
    addr_onehot = {{(NUM_OPS-1){1'b0}}, 1'b1} << address;
    clear_mask  = accept ? addr_onehot : '0;
    ptr_next    = (address == ADDR_W'(NUM_OPS - 1)) ? '0 : address + 1'b1;
  end

  // Issue FSM with registered handshake, grant, pending and overrun state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      address    <= '0;
      addr_valid <= 1'b0;
      grant      <= '0;
      pending    <= '0;
      overrun    <= 1'b0;
      ptr        <= '0;
      gap_cnt    <= '0;
    end else if (flush) begin
      // Flush drops all queued work and any request/accept on this edge; ptr is kept.
      state      <= IDLE;
      addr_valid <= 1'b0;
      grant      <= '0;
      pending    <= '0;
      overrun    <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      grant   <= '0;
      // A new request on the bit being retired keeps it pending (set wins).
      pending <= (pending & ~clear_mask) | req;
      if (|(req & pending)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (found) begin
            address    <= winner;
            addr_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // The issued address is frozen here; later requests wait their turn.
          if (addr_ready) begin
            grant      <= addr_onehot;
            addr_valid <= 1'b0;
            ptr        <= ptr_next;
            gap_cnt    <= GAP_W'(GAP_CYCLES);
            state      <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt <= GAP_W'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          addr_valid <= 1'b0;
        end
      endcase
    end
  end

  // busy mirrors the registered FSM state.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: directed vectors, an abstract
// per-edge model compared every cycle, a grant-order scoreboard, and
// hand-computed literal expectations at key points.
module tb_alu_op_issuer;

  localparam int NUM_OPS = 8;
  localparam int ADDR_W  = 3;
  localparam int GAP     = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_OPS-1:0] req = '0;
  logic               flush = 1'b0;
  logic               addr_ready = 1'b0;
  logic [ADDR_W-1:0]  address;
  logic               addr_valid;
  logic [NUM_OPS-1:0] grant;
  logic [NUM_OPS-1:0] pending;
  logic               busy;
  logic               overrun;

  alu_op_issuer #(
    .NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP), .GAP_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .flush(flush), .addr_ready(addr_ready),
    .address(address), .addr_valid(addr_valid), .grant(grant), .pending(pending),
    .busy(busy), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the queue of requests, whether an address is on offer, and how
  // many idle cycles remain before a new address may be offered.
  typedef struct packed {
    logic [7:0] pend;
    logic [2:0] ptr;
    logic       valid;
    logic [2:0] addr;
    logic [7:0] grant;
    logic       ovr;
    logic [3:0] hold;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, logic [7:0] r, logic fl, logic rdy);
    model_t n = s;
    logic [7:0] clr = '0;
    bit found = 0;
    n.grant = '0;
    if (fl) begin
      n.pend = '0; n.ovr = 1'b0; n.valid = 1'b0; n.hold = '0;
      return n;
    end
    if ((r & s.pend) != 0) n.ovr = 1'b1;
    if (s.valid) begin
      if (rdy) begin
        clr     = 8'd1 << s.addr;
        n.grant = clr;
        n.valid = 1'b0;
        n.ptr   = 3'((int'(s.addr) + 1) % NUM_OPS);
        n.hold  = 4'(GAP);
      end
    end else if (s.hold != 0) begin
      n.hold = s.hold - 4'd1;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        int j;
        j = (int'(s.ptr) + i) % NUM_OPS;
        if (!found && s.pend[j]) begin
          found  = 1;
          n.addr = 3'(j);
        end
      end
      n.valid = found;
    end
    n.pend = (s.pend & ~clr) | r;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, req, flush, addr_ready);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("addr_valid", {31'd0, addr_valid}, {31'd0, m.valid});
    chk("grant", {24'd0, grant}, {24'd0, m.grant});
    chk("pending", {24'd0, pending}, {24'd0, m.pend});
    chk("busy", {31'd0, busy}, {31'd0, (m.valid || m.hold != 0)});
    chk("overrun", {31'd0, overrun}, {31'd0, m.ovr});
    if (m.valid) chk("address", {29'd0, address}, {29'd0, m.addr});
  end

  // ---------------- grant-order scoreboard ----------------
  logic [ADDR_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && grant != 0) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", {24'd0, grant}, 32'd0);
      end else begin
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        chk("grant_order", {24'd0, grant}, 32'd1 << e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic [7:0] v);
    @(negedge clk); req = v;
    @(negedge clk); req = '0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!addr_valid && n < max_cycles) begin
      @(negedge clk); n++;
    end
    chk("valid_timeout", {31'd0, addr_valid}, 32'd1);
  endtask

  task automatic wait_drained(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk); n++;
    end
    chk("grant_timeout", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, addr_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pending", {24'd0, pending}, 32'd0);
    rst_n = 1'b1;

    // 1: reset asserted mid-issue clears outputs immediately, no grant
    pulse(8'h08);
    wait_valid(4);
    chk("t1_addr", {29'd0, address}, 32'd3);
    #2;
    addr_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t1_async_valid", {31'd0, addr_valid}, 32'd0);
    chk("t1_async_addr", {29'd0, address}, 32'd0);
    chk("t1_async_pending", {24'd0, pending}, 32'd0);
    chk("t1_async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t1_no_grant", {24'd0, grant}, 32'd0);
    rst_n = 1'b1;
    addr_ready = 1'b0;

    // 2: single op, two-edge latency, one-cycle grant, gap of one
    @(negedge clk); req = 8'h04; addr_ready = 1'b1; exp_q.push_back(3'd2);
    @(negedge clk); req = '0;
    chk("t2_pending", {24'd0, pending}, 32'h04);
    chk("t2_not_yet_valid", {31'd0, addr_valid}, 32'd0);
    @(negedge clk);
    chk("t2_valid", {31'd0, addr_valid}, 32'd1);
    chk("t2_addr", {29'd0, address}, 32'd2);
    chk("t2_busy_issue", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t2_grant", {24'd0, grant}, 32'h04);
    chk("t2_pending_clr", {24'd0, pending}, 32'd0);
    chk("t2_valid_drop", {31'd0, addr_valid}, 32'd0);
    chk("t2_busy_gap", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t2_grant_off", {24'd0, grant}, 32'd0);
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // 3: round-robin from a fresh pointer, then after the pointer moves past 0
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(3'd0); exp_q.push_back(3'd7);
    pulse(8'h81);
    wait_drained(20);
    exp_q.push_back(3'd0);
    pulse(8'h01);
    wait_drained(20);
    exp_q.push_back(3'd7); exp_q.push_back(3'd0);
    pulse(8'h81);
    wait_drained(20);

    // 4: backpressure holds the offered address; a newer req does not preempt
    addr_ready = 1'b0;
    exp_q.push_back(3'd5); exp_q.push_back(3'd0);
    pulse(8'h20);
    wait_valid(4);
    chk("t4_addr", {29'd0, address}, 32'd5);
    pulse(8'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", {31'd0, addr_valid}, 32'd1);
      chk("t4_hold_addr", {29'd0, address}, 32'd5);
    end
    addr_ready = 1'b1;
    wait_drained(20);

    // 5: overrun on repeated req, and req on the accept edge keeps the bit
    addr_ready = 1'b0;
    chk("t5_ovr_clear", {31'd0, overrun}, 32'd0);
    pulse(8'h08);
    wait_valid(4);
    chk("t5_addr", {29'd0, address}, 32'd3);
    pulse(8'h08);
    chk("t5_overrun", {31'd0, overrun}, 32'd1);
    chk("t5_pending", {24'd0, pending}, 32'h08);
    @(negedge clk); req = 8'h08; addr_ready = 1'b1;
    exp_q.push_back(3'd3); exp_q.push_back(3'd3);
    @(negedge clk); req = '0;
    chk("t5_grant", {24'd0, grant}, 32'h08);
    chk("t5_kept", {24'd0, pending}, 32'h08);
    wait_drained(20);

    // 6: flush during issue drops everything, including same-edge req/ready
    addr_ready = 1'b0;
    pulse(8'h3C);
    wait_valid(4);
    chk("t6_pending", {24'd0, pending}, 32'h3C);
    chk("t6_addr", {29'd0, address}, 32'd4);
    flush = 1'b1; addr_ready = 1'b1; req = 8'h01;
    @(negedge clk);
    flush = 1'b0; addr_ready = 1'b0; req = '0;
    chk("t6_pending_clr", {24'd0, pending}, 32'd0);
    chk("t6_valid", {31'd0, addr_valid}, 32'd0);
    chk("t6_grant", {24'd0, grant}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    chk("t6_stay_idle", {31'd0, addr_valid}, 32'd0);
    chk("t6_no_grant", {24'd0, grant}, 32'd0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
